// File: rtl/delay_timer_pkg.sv
// Shared types and constants for the delay timer bank.
// Optional feature macro: DELAY_TIMER_RETRIGGER_EN.
package delay_timer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_COUNT = 2'd1,
      ST_DONE  = 2'd2
   } dt_state_e;

   // Pulse counter holds DONE_WIDTH-1; never narrower than one bit.
   function automatic int unsigned pcnt_w(int unsigned dw);
      return (dw > 1) ? $clog2(dw) : 1;
   endfunction

endpackage

// File: rtl/delay_timer_if.sv
// Control/status bundle between phase-delay registers and the timer bank.
// Optional feature macro: DELAY_TIMER_RETRIGGER_EN.
interface delay_timer_if #(
   parameter int NUM_CH       = 4,
   parameter int COUNTER_SIZE = 5
);
   logic [NUM_CH-1:0]              start;
   logic [NUM_CH-1:0]              stop;
   logic [NUM_CH-1:0]              periodic;
   logic [NUM_CH*COUNTER_SIZE-1:0] count_time;
   logic [NUM_CH-1:0]              busy;
   logic [NUM_CH-1:0]              done_flag;

   modport master (
      output start, stop, periodic, count_time,
      input  busy, done_flag
   );

   modport slave (
      input  start, stop, periodic, count_time,
      output busy, done_flag
   );
endinterface

// File: rtl/delay_timer_channel.sv
// One delay timer channel: IDLE/COUNT/DONE FSM, down-counter, pulse counter.
// Optional feature macro: DELAY_TIMER_RETRIGGER_EN (restart from COUNT/DONE).
module delay_timer_channel
   import delay_timer_pkg::*;
#(
   parameter int COUNTER_SIZE = 5,
   parameter int DONE_WIDTH   = 3
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic                    stop,
   input  logic                    periodic,
   input  logic [COUNTER_SIZE-1:0] count_time,
   output logic                    busy,
   output logic                    done_flag
);

   localparam int PW = pcnt_w(DONE_WIDTH);
   localparam logic [PW-1:0] PULSE_LAST = PW'(DONE_WIDTH - 1);

   dt_state_e             state_q, state_d;
   logic [COUNTER_SIZE-1:0] cnt_q, cnt_d;
   logic [COUNTER_SIZE-1:0] t_q, t_d;
   logic                  mode_q, mode_d;
   logic [PW-1:0]         pcnt_q, pcnt_d;

   // State and counter registers, cleared asynchronously.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         t_q     <= '0;
         mode_q  <= 1'b0;
         pcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         t_q     <= t_d;
         mode_q  <= mode_d;
         pcnt_q  <= pcnt_d;
      end
   end

   // Next-state and counter update; stop overrides everything.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      t_d     = t_q;
      mode_d  = mode_q;
      pcnt_d  = pcnt_q;
      if (stop) begin
         state_d = ST_IDLE;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (start) begin
                  t_d     = count_time;
                  mode_d  = periodic;
                  cnt_d   = count_time;
                  state_d = ST_COUNT;
               end
            end
            ST_COUNT: begin
               if (cnt_q == '0) begin
                  pcnt_d  = PULSE_LAST;
                  state_d = ST_DONE;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
            ST_DONE: begin
               if (pcnt_q == '0) begin
                  if (mode_q) begin
                     cnt_d   = t_q;
                     state_d = ST_COUNT;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end else begin
                  pcnt_d = pcnt_q - 1'b1;
               end
            end
            default: state_d = ST_IDLE;
         endcase
`ifdef DELAY_TIMER_RETRIGGER_EN
         // A fresh start while active restarts the delay from current inputs.
         if (start && state_q != ST_IDLE) begin
            t_d     = count_time;
            mode_d  = periodic;
            cnt_d   = count_time;
            state_d = ST_COUNT;
         end
`endif
      end
   end

   assign busy      = (state_q != ST_IDLE);
   assign done_flag = (state_q == ST_DONE);

endmodule

// File: rtl/delay_timer_bank.sv
// Bank of NUM_CH independent one-shot/periodic delay timers.
// Optional feature macro: DELAY_TIMER_RETRIGGER_EN.
module delay_timer_bank
   import delay_timer_pkg::*;
#(
   parameter int NUM_CH       = 4,
   parameter int COUNTER_SIZE = 5,
   parameter int DONE_WIDTH   = 3
) (
   input logic          clk,
   input logic          rst,
   delay_timer_if.slave bus
);

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      delay_timer_channel #(
         .COUNTER_SIZE (COUNTER_SIZE),
         .DONE_WIDTH   (DONE_WIDTH)
      ) u_ch (
         .clk        (clk),
         .rst        (rst),
         .start      (bus.start[i]),
         .stop       (bus.stop[i]),
         .periodic   (bus.periodic[i]),
         .count_time (bus.count_time[i*COUNTER_SIZE +: COUNTER_SIZE]),
         .busy       (bus.busy[i]),
         .done_flag  (bus.done_flag[i])
      );
   end

endmodule

// File: tb/tb_delay_timer_bank.sv
// Directed, table-driven bench for delay_timer_bank.
// Honours DELAY_TIMER_RETRIGGER_EN for the retrigger expectations.
module tb_delay_timer_bank;

   typedef struct {
      logic [3:0]  st;
      logic [3:0]  sp;
      logic [3:0]  pe;
      logic [19:0] ct;
      logic [3:0]  eb;
      logic [3:0]  ed;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   tests = 0;
   int   fails = 0;
   vec_t tbl [26];

   always #5 clk = ~clk;

   delay_timer_if #(.NUM_CH(4), .COUNTER_SIZE(5)) bus ();

   delay_timer_bank #(
      .NUM_CH       (4),
      .COUNTER_SIZE (5),
      .DONE_WIDTH   (3)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   function automatic logic [19:0] mk_ct(int c0, int c1, int c2, int c3);
      return {c3[4:0], c2[4:0], c1[4:0], c0[4:0]};
   endfunction

   task automatic chk(input string nm, input logic [3:0] act,
                      input logic [3:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %b want %b", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] st, input logic [3:0] sp,
                        input logic [3:0] pe, input logic [19:0] ct);
      bus.start      = st;
      bus.stop       = sp;
      bus.periodic   = pe;
      bus.count_time = ct;
   endtask

   initial begin
      logic [3:0] eb, ed;
      int c31;

      // ch1 one-shot T=5, ch3 start+stop together stays idle
      tbl[0] = '{4'b1010, 4'b1000, 4'b0000, mk_ct(0, 5, 0, 0),
                 4'b0010, 4'b0000};
      for (int i = 1; i <= 5; i++)
         tbl[i] = '{4'b0000, 4'b0000, 4'b0000, mk_ct(0, 31, 0, 0),
                    4'b0010, 4'b0000};
      for (int i = 6; i <= 8; i++)
         tbl[i] = '{4'b0000, 4'b0000, 4'b0000, mk_ct(0, 31, 0, 0),
                    4'b0010, 4'b0010};
      tbl[9] = '{4'b0000, 4'b0000, 4'b0000, '0, 4'b0000, 4'b0000};
      // ch2 periodic T=0: period 4, pattern 0,1,1,1
      tbl[10] = '{4'b0100, 4'b0000, 4'b0100, mk_ct(0, 0, 0, 0),
                  4'b0100, 4'b0000};
      for (int i = 11; i <= 13; i++)
         tbl[i] = '{4'b0000, 4'b0000, 4'b0000, mk_ct(0, 0, 7, 0),
                    4'b0100, 4'b0100};
      tbl[14] = '{4'b0000, 4'b0000, 4'b0000, mk_ct(0, 0, 7, 0),
                  4'b0100, 4'b0000};
      for (int i = 15; i <= 17; i++)
         tbl[i] = '{4'b0000, 4'b0000, 4'b0000, mk_ct(0, 0, 7, 0),
                    4'b0100, 4'b0100};
      tbl[18] = '{4'b0000, 4'b0000, 4'b0000, '0, 4'b0100, 4'b0000};
      tbl[19] = '{4'b0000, 4'b0100, 4'b0000, '0, 4'b0000, 4'b0000};
      tbl[20] = '{4'b0000, 4'b0000, 4'b0000, '0, 4'b0000, 4'b0000};
      // ch3 T=2, stop lands on the expiry cycle
      tbl[21] = '{4'b1000, 4'b0000, 4'b0000, mk_ct(0, 0, 0, 2),
                  4'b1000, 4'b0000};
      tbl[22] = '{4'b0000, 4'b0000, 4'b0000, '0, 4'b1000, 4'b0000};
      tbl[23] = '{4'b0000, 4'b0000, 4'b0000, '0, 4'b1000, 4'b0000};
      tbl[24] = '{4'b0000, 4'b1000, 4'b0000, '0, 4'b0000, 4'b0000};
      tbl[25] = '{4'b0000, 4'b0000, 4'b0000, '0, 4'b0000, 4'b0000};

      drive('0, '0, '0, '0);
      #2;
      chk("rst_busy", bus.busy, 4'b0000);
      chk("rst_done", bus.done_flag, 4'b0000);
      step();
      step();
      rst = 1'b0;
      step();
      chk("idle_busy", bus.busy, 4'b0000);

      for (int i = 0; i < 26; i++) begin
         drive(tbl[i].st, tbl[i].sp, tbl[i].pe, tbl[i].ct);
         step();
         chk($sformatf("tbl%0d_busy", i), bus.busy, tbl[i].eb);
         chk($sformatf("tbl%0d_done", i), bus.done_flag, tbl[i].ed);
      end

      // async reset mid-count on ch0, T=10
      drive(4'b0001, '0, '0, mk_ct(10, 0, 0, 0));
      step();
      drive('0, '0, '0, '0);
      for (int i = 0; i < 3; i++) step();
      chk("pre_rst_busy", bus.busy, 4'b0001);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_busy", bus.busy, 4'b0000);
      chk("async_rst_done", bus.done_flag, 4'b0000);
      step();
      step();
      rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step();
         chk($sformatf("post_rst%0d", i), bus.busy | bus.done_flag, 4'b0000);
      end

      // staggered starts, T=31 on all channels; later count_time ignored
      for (int i = 0; i < 40; i++) begin
         logic [19:0] ct;
         logic [3:0]  st;
         for (int c = 0; c < 4; c++) begin
            c31 = (i == c) ? 31 : 3;
            ct[c*5 +: 5] = c31[4:0];
            st[c] = (i == c);
         end
         drive(st, '0, '0, ct);
         step();
         for (int c = 0; c < 4; c++) begin
            eb[c] = (i >= c) && (i <= c + 34);
            ed[c] = (i >= c + 32) && (i <= c + 34);
         end
         chk($sformatf("stag%0d_busy", i), bus.busy, eb);
         chk($sformatf("stag%0d_done", i), bus.done_flag, ed);
      end

      // second start on ch0 at count cycle 4 with T=3
      drive(4'b0001, '0, '0, mk_ct(8, 0, 0, 0));
      step();
      for (int i = 1; i <= 14; i++) begin
         if (i == 4) drive(4'b0001, '0, '0, mk_ct(3, 0, 0, 0));
         else        drive(4'b0000, '0, '0, mk_ct(8, 0, 0, 0));
         step();
`ifdef DELAY_TIMER_RETRIGGER_EN
         ed = {3'b000, 1'((i >= 8) && (i <= 10))};
`else
         ed = {3'b000, 1'((i >= 9) && (i <= 11))};
`endif
         chk($sformatf("retrig%0d_done", i), bus.done_flag, ed);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/delay_timer_bank.md
# delay_timer_bank

Parametrised bank of independent one-shot/periodic delay timers for the phase-delay datapath. Each channel loads a programmable cycle count on `start`, counts down, then raises `done_flag` for a fixed number of cycles. A channel either returns to idle or reloads and repeats. The block sits between the phase-delay control registers and the trigger/gate outputs, and replaces single fixed-count timers.

## Interface
- `NUM_CH`, 4: number of independent channels (≥1).
- `COUNTER_SIZE`, 5: bits per channel count value and down-counter.
- `DONE_WIDTH`, 3: cycles `done_flag` stays high per expiry (1..255).
- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  NUM_CH  per-channel start request, level-sampled each cycle.
- `stop`  in  NUM_CH  per-channel abort, level-sampled.
- `periodic`  in  NUM_CH  per-channel mode, sampled with `start`: 1 = auto-reload, 0 = one-shot.
- `count_time`  in  NUM_CH*COUNTER_SIZE  delay per channel; channel i uses bits [i*COUNTER_SIZE +: COUNTER_SIZE]; sampled with `start`.
- `busy`  out  NUM_CH  channel in COUNT or DONE.
- `done_flag`  out  NUM_CH  expiry pulse, DONE_WIDTH cycles.

## Operation
- Per-channel FSM, states IDLE, COUNT, DONE; channels fully independent.
- Reset: state IDLE, counters 0, latched T and mode 0; `busy`=0, `done_flag`=0, asynchronously.
- IDLE: `start`=1 → latch T=`count_time` slice and `periodic`, load down-counter with T, go COUNT.
- COUNT: counter==0 → go DONE, load pulse counter with DONE_WIDTH-1; else decrement. No wrap: counter never decrements below 0.
- DONE: pulse counter==0 → if latched periodic, reload down-counter with latched T, go COUNT; else go IDLE. Otherwise decrement the pulse counter.
- `start` in COUNT/DONE: ignored unless the retrigger feature is compiled in.
- `stop`=1 in any state → IDLE next edge. `stop` wins over simultaneous `start`, expiry, or reload.
- `count_time`/`periodic` changes after the start cycle have no effect until the next accepted `start`.
- T=0 is legal: minimum delay.
- Outputs are registered: `busy` = (state != IDLE); `done_flag` = (state == DONE).

## Timing
- `start` sampled at edge k (IDLE) → `busy` high after k; `done_flag` high after edge k+T+1 through edge k+T+1+DONE_WIDTH, i.e. exactly DONE_WIDTH cycles.
- One-shot: `busy` falls together with `done_flag`. A `start` held high in that cycle is accepted one edge later: `start` is sampled in IDLE only.
- Periodic: expiry period = T+1+DONE_WIDTH cycles; `done_flag` falls for T+1 cycles between pulses.
- `stop` at edge j → `busy`=`done_flag`=0 after edge j.
- `rst` mid-count: outputs clear immediately, not waiting for a clock edge; after release, the channel waits for a fresh `start`.

## Configuration
- `DELAY_TIMER_RETRIGGER_EN` defined: `start`=1 (and `stop`=0) in COUNT or DONE reloads T, mode and down-counter from current inputs and goes COUNT. A retrigger in DONE truncates the pulse: `done_flag` low next cycle.
- Not defined: `start` outside IDLE is ignored, as in Operation.

## Structure
- Package `delay_timer_pkg`: state encoding typedef (IDLE/COUNT/DONE) and derived constant for pulse-counter width, `$clog2(DONE_WIDTH)` with a minimum of 1.
- One sub-module `delay_timer_channel`: single-channel FSM plus counters. Top level generates NUM_CH instances and slices `count_time`.

## Test plan
- Reset/idle: assert `rst` mid-count on ch0 (T=10, cycle 4) → `busy`/`done_flag` clear without clock edge; no pulse after release.
- One-shot latency: ch1 T=5, periodic=0, start at edge k → `done_flag[1]` high edges k+6..k+8 (3 cycles), `busy[1]` low after k+9.
- Periodic + T=0: ch2 T=0, periodic=1 → `done_flag[2]` pattern 0,1,1,1 repeating (period 4); `stop` pulse → low next edge, stays low.
- Priority: ch3 `start` and `stop` same cycle in IDLE → stays IDLE. `stop` on the expiry cycle (counter==0) → no `done_flag`.
- Independence/full range: all channels T=31 (max), staggered starts → each pulses exactly 32 cycles after its own start; changing `count_time` mid-count has no effect.
- Retrigger (macro on/off): ch0 T=8, second `start` with T=3 at count cycle 4 → with macro, done 4 cycles later; without, done at original time.
